// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment refresh controller.
package disp_scan_ctrl_pkg;

  localparam int unsigned NumDigits = 4;
  localparam int unsigned NibbleW   = 4;
  localparam int unsigned ScanW     = 2;
  localparam int unsigned HexsW     = NumDigits * NibbleW;

  typedef enum logic {
    StIdle = 1'b0,
    StPend = 1'b1
  } hs_state_e;

  typedef struct packed {
    logic [HexsW-1:0]     hexs;
    logic [NumDigits-1:0] point;
    logic [NumDigits-1:0] les;
  } disp_word_t;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Load handshake between the display content producer and the refresh controller.
interface disp_scan_ctrl_if;
  import disp_scan_ctrl_pkg::*;

  logic                 ld_valid;
  logic                 ld_ready;
  logic [HexsW-1:0]     ld_hexs;
  logic [NumDigits-1:0] ld_point;
  logic [NumDigits-1:0] ld_les;
  logic [NumDigits-1:0] ld_blink;

  modport master (
    output ld_valid, ld_hexs, ld_point, ld_les, ld_blink,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_hexs, ld_point, ld_les, ld_blink,
    output ld_ready
  );

endinterface

// File: rtl/disp_scan_ctrl_prescaler.sv
// Free-running W-bit divider; tick_o pulses on the enabled cycle where the count wraps.
module disp_scan_ctrl_prescaler #(
  parameter int unsigned W = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == {W{1'b1}});

endmodule

// File: rtl/disp_scan_ctrl.sv
// Seven-segment refresh controller: digit scan plus tear-free content commit at frame end.
// Optional DISP_BLINK_EN adds per-digit blinking driven by a frame-rate divider.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned PRESC_W = 17,
  parameter int unsigned BLINK_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  disp_scan_ctrl_if.slave      ld,
  output logic [HexsW-1:0]     Hexs,
  output logic [NumDigits-1:0] Point,
  output logic [NumDigits-1:0] Les,
  output logic [ScanW-1:0]     Scan
);

  logic       tick;
  logic       frame_end;
  hs_state_e  state_q;
  logic       ready_q;
  logic [ScanW-1:0] scan_q;
  disp_word_t shadow_q;
  disp_word_t word_q;

  disp_scan_ctrl_prescaler #(
    .W (PRESC_W)
  ) u_scan_presc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .tick_o (tick)
  );

  assign frame_end = tick && (scan_q == ScanW'(NumDigits - 1));

  // Commit shares the edge where Scan wraps 3->0, so new contents start at digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ready_q  <= 1'b1;
      scan_q   <= '0;
      shadow_q <= '0;
      word_q   <= '0;
    end else begin
      if (tick) begin
        scan_q <= scan_q + ScanW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (ld.ld_valid) begin
            shadow_q <= '{hexs: ld.ld_hexs, point: ld.ld_point, les: ld.ld_les};
            state_q  <= StPend;
            ready_q  <= 1'b0;
          end
        end
        StPend: begin
          if (frame_end) begin
            word_q  <= shadow_q;
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ld.ld_ready = ready_q;
  assign Hexs        = word_q.hexs;
  assign Point       = word_q.point;
  assign Scan        = scan_q;

`ifdef DISP_BLINK_EN
  logic                 blink_tick;
  logic                 phase_q;
  logic [NumDigits-1:0] blink_sh_q;
  logic [NumDigits-1:0] blink_q;

  disp_scan_ctrl_prescaler #(
    .W (BLINK_W)
  ) u_blink_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (frame_end),
    .tick_o (blink_tick)
  );

  // Blink bits travel through the same shadow/commit path as the rest of the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      blink_sh_q <= '0;
      blink_q    <= '0;
    end else begin
      if (blink_tick) begin
        phase_q <= ~phase_q;
      end
      if (state_q == StIdle && ld.ld_valid) begin
        blink_sh_q <= ld.ld_blink;
      end
      if (state_q == StPend && frame_end) begin
        blink_q <= blink_sh_q;
      end
    end
  end

  assign Les = word_q.les | (blink_q & {NumDigits{phase_q}});
`else
  localparam int unsigned UnusedBlinkW = BLINK_W;
  logic [NumDigits-1:0] unused_blink;
  logic [31:0]          unused_blink_w;

  assign unused_blink   = ld.ld_blink;
  assign unused_blink_w = UnusedBlinkW;
  assign Les            = word_q.les;
`endif

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with PRESC_W=2, BLINK_W=1; the reference is an
// arithmetic model over the count of clocks since reset.
module tb_disp_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_scan_ctrl_if ld_if ();

  logic [15:0] hexs;
  logic [3:0]  point;
  logic [3:0]  les;
  logic [1:0]  scan;

  disp_scan_ctrl #(
    .PRESC_W (2),
    .BLINK_W (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld_if),
    .Hexs  (hexs),
    .Point (point),
    .Les   (les),
    .Scan  (scan)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: n = clock edges since reset released.
  int          n = 0;
  bit          pend = 1'b0;
  logic [15:0] sh_h = '0, m_h = '0;
  logic [3:0]  sh_p = '0, sh_l = '0, sh_b = '0;
  logic [3:0]  m_p = '0, m_l = '0, m_b = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [15:0] h, input logic [3:0] p,
                      input logic [3:0] l, input logic [3:0] b);
    logic [3:0] exp_les;
    bit         phase;
    rst               = r;
    ld_if.ld_valid    = v;
    ld_if.ld_hexs     = h;
    ld_if.ld_point    = p;
    ld_if.ld_les      = l;
    ld_if.ld_blink    = b;
    @(posedge clk);
    if (r) begin
      n = 0; pend = 1'b0;
      m_h = '0; m_p = '0; m_l = '0; m_b = '0;
      sh_h = '0; sh_p = '0; sh_l = '0; sh_b = '0;
    end else begin
      n++;
      if (!pend) begin
        if (v) begin
          pend = 1'b1; sh_h = h; sh_p = p; sh_l = l; sh_b = b;
        end
      end else if (n % 16 == 0) begin
        pend = 1'b0; m_h = sh_h; m_p = sh_p; m_l = sh_l; m_b = sh_b;
      end
    end
    phase = ((n / 32) % 2) == 1;
`ifdef DISP_BLINK_EN
    exp_les = m_l | (m_b & {4{phase}});
`else
    exp_les = m_l;
`endif
    #1;
    check("scan",  32'(scan),  32'((n / 4) % 4));
    check("ready", 32'(ld_if.ld_ready), 32'(!pend));
    check("hexs",  32'(hexs),  32'(m_h));
    check("point", 32'(point), 32'(m_p));
    check("les",   32'(les),   32'(exp_les));
  endtask

  initial begin
    rst = 1'b1;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_hexs  = '0;
    ld_if.ld_point = '0;
    ld_if.ld_les   = '0;
    ld_if.ld_blink = '0;

    // Reset and free-running scan
    repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    check("reset_ready", 32'(ld_if.ld_ready), 32'd1);
    check("reset_hexs", 32'(hexs), 32'd0);
    repeat (21) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);

    // Mid-frame load, then FFFF held while pending
    step(1'b0, 1'b1, 16'h1234, 4'b0100, 4'h0, 4'h0);
    check("ready_after_load", 32'(ld_if.ld_ready), 32'd0);
    repeat (40) step(1'b0, 1'b1, 16'hFFFF, 4'h0, 4'h0, 4'h0);

    // Load presented exactly on the frame_end cycle while idle
    for (int i = 0; i < 40; i++) begin
      if (!pend && (n % 16 == 15)) break;
      step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    end
    check("fe_setup", 32'(n % 16), 32'd15);
    step(1'b0, 1'b1, 16'hABCD, 4'b1010, 4'b0001, 4'h0);
    check("fe_no_commit", 32'(hexs), 32'hFFFF);
    repeat (20) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    check("fe_late_commit", 32'(hexs), 32'hABCD);

    // Reset while pending discards the shadow
    step(1'b0, 1'b1, 16'h5A5A, 4'hF, 4'h0, 4'h0);
    repeat (2) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
      check("rst_no_commit", 32'(hexs), 32'd0);
    end

    // Blink on digit 0
    step(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0, 4'b0001);
    repeat (100) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
           16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
